// File: rtl/vga_timing_pkg.sv
// Shared GPU timing package.
// Holds the 800x600@60 Hz SVGA raster constants (40 MHz pixel clock), the
// derived totals and sync windows, and the 8x8 character-cell geometry used
// by the fetch logic.
package vga_timing_pkg;

  localparam int COORD_W   = 11;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 1056
  localparam int HS_START  = H_VISIBLE + H_FRONT;                     // 840
  localparam int HS_END    = HS_START + H_SYNC;                       // 968, exclusive

  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 628
  localparam int VS_START  = V_VISIBLE + V_FRONT;                     // 601
  localparam int VS_END    = VS_START + V_SYNC;                       // 605, exclusive

  localparam bit HSYNC_POL = 1'b1;
  localparam bit VSYNC_POL = 1'b1;

  // Character-cell geometry: 8x8 cells, 100 columns x 75 rows.
  localparam int CELL_SHIFT = 3;
  localparam int COLS       = 100;
  localparam int ROWS       = 75;

  // Cell index of a pixel coordinate.
  function automatic logic [COORD_W-1:0] cell_of(input logic [COORD_W-1:0] coord);
    return coord >> CELL_SHIFT;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the connector and the
// character/sprite fetch logic.
//   VGA_HSYNC / VGA_VSYNC : sync levels for the connector
//   pixel_x / pixel_y     : current raster position
//   on_screen             : position lies inside the visible area
// master = timing generator, slave = consumer.
interface vga_timing_if #(
  parameter int COORD_W = vga_timing_pkg::COORD_W
);
  import vga_timing_pkg::*;

  logic               VGA_HSYNC;
  logic               VGA_VSYNC;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               on_screen;

  modport master (output VGA_HSYNC, output VGA_VSYNC, output pixel_x,
                  output pixel_y, output on_screen);
  modport slave  (input  VGA_HSYNC, input  VGA_VSYNC, input  pixel_x,
                  input  pixel_y, input  on_screen);
endinterface

// File: rtl/vga_timing_axis_counter.sv
// One raster axis: a wrapping position counter with registered sync decode.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : advance the counter this edge
//   o_count        : registered position, 0..TOTAL-1
//   o_vis_nxt      : position about to be loaded lies in the visible range
//   o_sync         : registered sync at its SYNC_POL active level in the window
module vga_axis_counter #(
  parameter int COORD_W    = 11,
  parameter int TOTAL      = 1056,
  parameter int VISIBLE    = 800,
  parameter int SYNC_START = 840,
  parameter int SYNC_END   = 968,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_count,
  output logic               o_vis_nxt,
  output logic               o_sync
);
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] r_count;
  logic               r_sync;
  logic [COORD_W-1:0] w_nxt;
  logic               w_sync_nxt;

  // Decoding is done on the next value so the registered sync lines up with
  // the registered count (no skew between position and sync).
  always_comb begin
    w_nxt = r_count;
    if (i_en) begin
      if (r_count == COORD_W'(TOTAL - 1)) w_nxt = '0;
      else                                w_nxt = r_count + 1'b1;
    end
    w_sync_nxt = (w_nxt >= COORD_W'(SYNC_START)) && (w_nxt < COORD_W'(SYNC_END));
    o_vis_nxt  = (w_nxt < COORD_W'(VISIBLE));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_sync  <= ~SYNC_POL;
    end else begin
      r_count <= w_nxt;
      r_sync  <= w_sync_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_count = r_count;
  assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator (default 800x600@60 Hz from a 40 MHz clock).
// Ports:
//   CLK_PIXEL : pixel clock, all logic on the rising edge
//   RST       : synchronous active-low reset
//   vga       : master side of vga_timing_if (syncs, pixel_x/y, on_screen)
// Every output is a register; position, syncs and on_screen all describe the
// same raster position. The first edge after reset already steps to (1,0).
module vga_timing #(
  parameter int COORD_W   = vga_timing_pkg::COORD_W,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit HSYNC_POL = vga_timing_pkg::HSYNC_POL,
  parameter bit VSYNC_POL = vga_timing_pkg::VSYNC_POL
) (
  input  logic         CLK_PIXEL,
  input  logic         RST,
  vga_timing_if.master vga
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SS  = H_VISIBLE + H_FRONT;
  localparam int H_SE  = H_SS + H_SYNC;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SS  = V_VISIBLE + V_FRONT;
  localparam int V_SE  = V_SS + V_SYNC;

  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;
  logic               w_h_wrap;
  logic               w_h_vis_nxt;
  logic               w_v_vis_nxt;
  logic               w_hsync;
  logic               w_vsync;
  logic               r_on_screen;

  // The vertical axis steps only on the last pixel of a line, so VSYNC and
  // pixel_y change together at pixel_x == 0.
  assign w_h_wrap = (w_px == COORD_W'(H_TOT - 1));

  vga_axis_counter #(
    .COORD_W(COORD_W), .TOTAL(H_TOT), .VISIBLE(H_VISIBLE),
    .SYNC_START(H_SS), .SYNC_END(H_SE), .SYNC_POL(HSYNC_POL)
  ) u_h (
    .i_clk(CLK_PIXEL), .i_rst_n(RST), .i_en(1'b1),
    .o_count(w_px), .o_vis_nxt(w_h_vis_nxt), .o_sync(w_hsync)
  );

  vga_axis_counter #(
    .COORD_W(COORD_W), .TOTAL(V_TOT), .VISIBLE(V_VISIBLE),
    .SYNC_START(V_SS), .SYNC_END(V_SE), .SYNC_POL(VSYNC_POL)
  ) u_v (
    .i_clk(CLK_PIXEL), .i_rst_n(RST), .i_en(w_h_wrap),
    .o_count(w_py), .o_vis_nxt(w_v_vis_nxt), .o_sync(w_vsync)
  );

  // on_screen is registered from the next-position decode of both axes so it
  // matches the position loaded on the same edge.
  always_ff @(posedge CLK_PIXEL) begin
    if (!RST) r_on_screen <= 1'b0;
    else      r_on_screen <= w_h_vis_nxt & w_v_vis_nxt;
  end

  assign vga.pixel_x   = w_px;
  assign vga.pixel_y   = w_py;
  assign vga.VGA_HSYNC = w_hsync;
  assign vga.VGA_VSYNC = w_vsync;
  assign vga.on_screen = r_on_screen;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;
  // Full SVGA timing
  localparam int HV = 800, HF = 40, HS = 128, HB = 88;
  localparam int VV = 600, VF = 1, VS = 4, VB = 23;
  localparam int FA = (HV + HF + HS + HB) * (VV + VF + VS + VB);   // 663168
  // Shrunken timing so whole frames fit in a short run
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;              // 32 per line
  localparam int SVV = 12, SVF = 2, SVS = 3, SVB = 3;              // 20 lines
  localparam int FS  = 32 * 20;

  typedef struct {
    int x; int y; bit on; bit hs; bit vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if #(.COORD_W(11)) if_a ();
  vga_timing_if #(.COORD_W(11)) if_b ();
  vga_timing_if #(.COORD_W(11)) if_s ();

  vga_timing #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1))
    u_a (.CLK_PIXEL(clk), .RST(rst_n), .vga(if_a));
  vga_timing #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0))
    u_b (.CLK_PIXEL(clk), .RST(rst_n), .vga(if_b));
  vga_timing #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
               .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
               .HSYNC_POL(1'b1), .VSYNC_POL(1'b1))
    u_s (.CLK_PIXEL(clk), .RST(rst_n), .vga(if_s));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the raster position is simply the number of edges since reset
  // release, taken modulo the frame, split into line and column.
  function automatic exp_t model(input int idx, input bit in_rst,
                                 input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht;
    bit hact, vact;
    ht   = hv + hf + hs + hb;
    e.x  = idx % ht;
    e.y  = idx / ht;
    e.on = !in_rst && (e.x < hv) && (e.y < vv);
    hact = !in_rst && (e.x >= hv + hf) && (e.x < hv + hf + hs);
    vact = !in_rst && (e.y >= vv + vf) && (e.y < vv + vf + vs);
    e.hs = hact ? hp : !hp;
    e.vs = vact ? vp : !vp;
    return e;
  endfunction

  int ia = 0, is = 0;
  bit in_rst = 1'b1, mvalid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      in_rst = 1'b1; ia = 0; is = 0; mvalid = 1'b1;
    end else begin
      in_rst = 1'b0; ia = (ia + 1) % FA; is = (is + 1) % FS;
    end
  end

  task automatic cmp(input string d, input exp_t e, input int x, input int y,
                     input bit on, input bit hs, input bit vs);
    check({d, ".pixel_x"},   x,  e.x);
    check({d, ".pixel_y"},   y,  e.y);
    check({d, ".on_screen"}, on, e.on);
    check({d, ".hsync"},     hs, e.hs);
    check({d, ".vsync"},     vs, e.vs);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      cmp("A", model(ia, in_rst, HV, HF, HS, HB, VV, VF, VS, VB, 1'b1, 1'b1),
          int'(if_a.pixel_x), int'(if_a.pixel_y), if_a.on_screen, if_a.VGA_HSYNC, if_a.VGA_VSYNC);
      cmp("B", model(ia, in_rst, HV, HF, HS, HB, VV, VF, VS, VB, 1'b0, 1'b0),
          int'(if_b.pixel_x), int'(if_b.pixel_y), if_b.on_screen, if_b.VGA_HSYNC, if_b.VGA_VSYNC);
      cmp("S", model(is, in_rst, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1, 1'b1),
          int'(if_s.pixel_x), int'(if_s.pixel_y), if_s.on_screen, if_s.VGA_HSYNC, if_s.VGA_VSYNC);
    end
  end

  // Sync period measurement: edges between consecutive rising edges.
  bit prev_sig [3];
  bit have_rise [3];
  int cnt [3];
  int n_per [3];
  always @(negedge clk) begin
    bit sig [3];
    int want [3];
    string nm [3];
    sig[0] = if_a.VGA_HSYNC; want[0] = HV + HF + HS + HB; nm[0] = "hsync_period_A";
    sig[1] = if_s.VGA_HSYNC; want[1] = 32;                nm[1] = "hsync_period_S";
    sig[2] = if_s.VGA_VSYNC; want[2] = FS;                nm[2] = "vsync_period_S";
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        if (in_rst) begin
          have_rise[k] = 1'b0; cnt[k] = 0;
        end else begin
          cnt[k]++;
          if (sig[k] && !prev_sig[k]) begin
            if (have_rise[k]) begin
              check(nm[k], cnt[k], want[k]);
              n_per[k]++;
            end
            have_rise[k] = 1'b1; cnt[k] = 0;
          end
        end
        prev_sig[k] = sig[k];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset for three edges
    rst_n = 1'b0;
    tick(3);
    check("rst_x",    int'(if_a.pixel_x), 0);
    check("rst_y",    int'(if_a.pixel_y), 0);
    check("rst_on",   if_a.on_screen, 0);
    check("rst_hs_A", if_a.VGA_HSYNC, 0);
    check("rst_vs_A", if_a.VGA_VSYNC, 0);
    check("rst_hs_B", if_b.VGA_HSYNC, 1);
    check("rst_vs_B", if_b.VGA_VSYNC, 1);
    rst_n = 1'b1;
    tick(1);
    check("first_x",  int'(if_a.pixel_x), 1);
    check("first_y",  int'(if_a.pixel_y), 0);
    check("first_on", if_a.on_screen, 1);

    // Line walk
    tick(798);
    check("x799_x",  int'(if_a.pixel_x), 799);
    check("x799_on", if_a.on_screen, 1);
    tick(1);
    check("x800_on", if_a.on_screen, 0);
    tick(39);
    check("x839_hs_A", if_a.VGA_HSYNC, 0);
    tick(1);
    check("x840_x",    int'(if_a.pixel_x), 840);
    check("x840_hs_A", if_a.VGA_HSYNC, 1);
    check("x840_hs_B", if_b.VGA_HSYNC, 0);
    tick(127);
    check("x967_hs_A", if_a.VGA_HSYNC, 1);
    tick(1);
    check("x968_hs_A", if_a.VGA_HSYNC, 0);
    check("x968_hs_B", if_b.VGA_HSYNC, 1);
    tick(87);
    check("x1055_x", int'(if_a.pixel_x), 1055);
    check("x1055_y", int'(if_a.pixel_y), 0);
    tick(1);
    check("wrap_x", int'(if_a.pixel_x), 0);
    check("wrap_y", int'(if_a.pixel_y), 1);

    // Mid-frame reset
    tick(500);
    check("mid_x", int'(if_a.pixel_x), 500);
    check("mid_y", int'(if_a.pixel_y), 1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_x",    int'(if_a.pixel_x), 0);
    check("midrst_y",    int'(if_a.pixel_y), 0);
    check("midrst_on",   if_a.on_screen, 0);
    check("midrst_hs_B", if_b.VGA_HSYNC, 1);
    check("midrst_vs_B", if_b.VGA_VSYNC, 1);
    rst_n = 1'b1;
    tick(1);
    check("restart_x",  int'(if_a.pixel_x), 1);
    check("restart_on", if_a.on_screen, 1);

    // Frame walk on the shrunken timing: VSYNC lines 14..16, wrap to (0,0)
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(447);
    check("s_y13",    int'(if_s.pixel_y), 13);
    check("s_y13_vs", if_s.VGA_VSYNC, 0);
    tick(1);
    check("s_y14_x",  int'(if_s.pixel_x), 0);
    check("s_y14_y",  int'(if_s.pixel_y), 14);
    check("s_y14_vs", if_s.VGA_VSYNC, 1);
    tick(191);
    check("s_last_x",  int'(if_s.pixel_x), 31);
    check("s_last_y",  int'(if_s.pixel_y), 19);
    check("s_last_on", if_s.on_screen, 0);
    tick(1);
    check("s_wrap_x",  int'(if_s.pixel_x), 0);
    check("s_wrap_y",  int'(if_s.pixel_y), 0);
    check("s_wrap_on", if_s.on_screen, 1);

    // Randomized run with sporadic resets
    for (int c = 0; c < 30000; c++) begin
      rst_n = ($urandom_range(0, 1999) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    check("hsync_period_A_seen", int'(n_per[0] > 0), 1);
    check("hsync_period_S_seen", int'(n_per[1] > 0), 1);
    check("vsync_period_S_seen", int'(n_per[2] > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
